// File: rtl/mpsoc_msi_ahb3_pkg.sv
// Shared AHB3-Lite encodings used by the MSI interconnect blocks.
package mpsoc_msi_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/mpsoc_msi_ahb3_arbiter.sv
// Combinational priority arbiter: highest 3-bit priority wins, ties resolved
// round-robin starting just after the previously granted master.
module mpsoc_msi_ahb3_arbiter #(
    parameter int MASTERS = 5,
    localparam int MB = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic [MASTERS-1:0]      req,
    input  logic [MASTERS-1:0][2:0] priorities,
    input  logic [MB-1:0]           last_granted,
    output logic [MASTERS-1:0]      winner
);

    logic [2:0]         top_prio;
    logic [MASTERS-1:0] eligible;
    logic               found;

    always_comb begin
        top_prio = '0;
        eligible = '0;
        winner   = '0;
        found    = 1'b0;

        for (int j = 0; j < MASTERS; j++) begin
            if (req[j] && (priorities[j] > top_prio)) begin
                top_prio = priorities[j];
            end
        end

        for (int j = 0; j < MASTERS; j++) begin
            eligible[j] = req[j] && (priorities[j] == top_prio);
        end

        // Two passes give the wrap: indices above last_granted first, then from 0.
        for (int j = 0; j < MASTERS; j++) begin
            if (!found && eligible[j] && (j > int'(last_granted))) begin
                winner[j] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int j = 0; j < MASTERS; j++) begin
            if (!found && eligible[j] && (j <= int'(last_granted))) begin
                winner[j] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpsoc_msi_ahb3_slave_port.sv
// Slave-side AHB3-Lite port: arbitrates master ports at transfer boundaries,
// forwards the owner's address phase and steers write data by data-phase owner.
module mpsoc_msi_ahb3_slave_port
    import mpsoc_msi_ahb3_pkg::*;
#(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,

    input  logic [MASTERS-1:0][2:0]   mst_priority,
    input  logic [MASTERS-1:0]        mstHSEL,
    input  logic [MASTERS-1:0][PLEN-1:0] mstHADDR,
    input  logic [MASTERS-1:0][XLEN-1:0] mstHWDATA,
    input  logic [MASTERS-1:0]        mstHWRITE,
    input  logic [MASTERS-1:0][2:0]   mstHSIZE,
    input  logic [MASTERS-1:0][2:0]   mstHBURST,
    input  logic [MASTERS-1:0][3:0]   mstHPROT,
    input  logic [MASTERS-1:0][1:0]   mstHTRANS,
    input  logic [MASTERS-1:0]        mstHMASTLOCK,
    input  logic [MASTERS-1:0]        mstHREADY,
    input  logic [MASTERS-1:0]        can_switch,

    output logic [MASTERS-1:0]        master_granted,
    output logic [XLEN-1:0]           mstHRDATA,
    output logic                      mstHREADYOUT,
    output logic                      mstHRESP,

    output logic                      slv_HSEL,
    output logic [PLEN-1:0]           slv_HADDR,
    output logic [XLEN-1:0]           slv_HWDATA,
    output logic                      slv_HWRITE,
    output logic [2:0]                slv_HSIZE,
    output logic [2:0]                slv_HBURST,
    output logic [3:0]                slv_HPROT,
    output logic [1:0]                slv_HTRANS,
    output logic                      slv_HMASTLOCK,
    output logic                      slv_HREADY,
    input  logic [XLEN-1:0]           slv_HRDATA,
    input  logic                      slv_HREADYOUT,
    input  logic                      slv_HRESP
);

    localparam int MB = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0] req;
    logic [MASTERS-1:0] winner;
    logic [MB-1:0]      winner_idx;
    logic [MB-1:0]      last_granted;
    logic [MB-1:0]      addr_sel;
    logic [MB-1:0]      data_sel;
    logic               data_valid;
    logic               granted_any;
    logic               owner_switch;
    logic               arb_en;

    always_comb begin
        req = '0;
        for (int m = 0; m < MASTERS; m++) begin
            req[m] = mstHSEL[m] & (mstHTRANS[m] != HTRANS_IDLE);
        end
    end

    mpsoc_msi_ahb3_arbiter #(
        .MASTERS      (MASTERS)
    ) u_arbiter (
        .req          (req),
        .priorities   (mst_priority),
        .last_granted (last_granted),
        .winner       (winner)
    );

    always_comb begin
        winner_idx = '0;
        addr_sel   = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (winner[m])         winner_idx = MB'(m);
            if (master_granted[m]) addr_sel   = MB'(m);
        end
    end

    // The bus only changes hands when the slave is ready and the owner is at a boundary.
    assign granted_any  = |master_granted;
    assign owner_switch = |(master_granted & can_switch);
    assign arb_en       = slv_HREADYOUT & (~granted_any | owner_switch);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            master_granted <= '0;
            last_granted   <= MB'(MASTERS - 1);
        end else if (arb_en) begin
            if (|req) begin
                master_granted <= winner;
                last_granted   <= winner_idx;
            end else begin
                master_granted <= '0;
            end
        end
    end

    // Address phase: combinational mux from the current owner.
    always_comb begin
        slv_HSEL      = 1'b0;
        slv_HADDR     = '0;
        slv_HWRITE    = 1'b0;
        slv_HSIZE     = '0;
        slv_HBURST    = '0;
        slv_HPROT     = '0;
        slv_HTRANS    = HTRANS_IDLE;
        slv_HMASTLOCK = 1'b0;
        if (granted_any) begin
            slv_HSEL      = mstHSEL[addr_sel];
            slv_HADDR     = mstHADDR[addr_sel];
            slv_HWRITE    = mstHWRITE[addr_sel];
            slv_HSIZE     = mstHSIZE[addr_sel];
            slv_HBURST    = mstHBURST[addr_sel];
            slv_HPROT     = mstHPROT[addr_sel];
            slv_HTRANS    = mstHTRANS[addr_sel];
            slv_HMASTLOCK = mstHMASTLOCK[addr_sel];
        end
    end

    // Data phase: follows the address phase one accepted transfer later.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_sel   <= '0;
            data_valid <= 1'b0;
        end else if (slv_HREADYOUT) begin
            data_sel   <= addr_sel;
            data_valid <= slv_HSEL & (slv_HTRANS != HTRANS_IDLE);
        end
    end

    assign slv_HWDATA = mstHWDATA[data_sel];
    assign slv_HREADY = data_valid ? mstHREADY[data_sel] : 1'b1;

    assign mstHRDATA    = slv_HRDATA;
    assign mstHREADYOUT = slv_HREADYOUT;
    assign mstHRESP     = slv_HRESP;

endmodule

// File: tb/tb_mpsoc_msi_ahb3_slave_port.sv
// Directed self-checking bench for the AHB3-Lite slave-side arbiter.
module tb_mpsoc_msi_ahb3_slave_port;
    import mpsoc_msi_ahb3_pkg::*;

    localparam int PLEN    = 64;
    localparam int XLEN    = 64;
    localparam int MASTERS = 5;

    logic                         HCLK = 1'b0;
    logic                         HRESETn;
    logic [MASTERS-1:0][2:0]      mst_priority;
    logic [MASTERS-1:0]           mstHSEL;
    logic [MASTERS-1:0][PLEN-1:0] mstHADDR;
    logic [MASTERS-1:0][XLEN-1:0] mstHWDATA;
    logic [MASTERS-1:0]           mstHWRITE;
    logic [MASTERS-1:0][2:0]      mstHSIZE;
    logic [MASTERS-1:0][2:0]      mstHBURST;
    logic [MASTERS-1:0][3:0]      mstHPROT;
    logic [MASTERS-1:0][1:0]      mstHTRANS;
    logic [MASTERS-1:0]           mstHMASTLOCK;
    logic [MASTERS-1:0]           mstHREADY;
    logic [MASTERS-1:0]           can_switch;
    logic [MASTERS-1:0]           master_granted;
    logic [XLEN-1:0]              mstHRDATA;
    logic                         mstHREADYOUT;
    logic                         mstHRESP;
    logic                         slv_HSEL;
    logic [PLEN-1:0]              slv_HADDR;
    logic [XLEN-1:0]              slv_HWDATA;
    logic                         slv_HWRITE;
    logic [2:0]                   slv_HSIZE;
    logic [2:0]                   slv_HBURST;
    logic [3:0]                   slv_HPROT;
    logic [1:0]                   slv_HTRANS;
    logic                         slv_HMASTLOCK;
    logic                         slv_HREADY;
    logic [XLEN-1:0]              slv_HRDATA;
    logic                         slv_HREADYOUT;
    logic                         slv_HRESP;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] rot_exp [5];

    mpsoc_msi_ahb3_slave_port #(
        .PLEN(PLEN), .XLEN(XLEN), .MASTERS(MASTERS)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mst_priority(mst_priority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR),
        .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE),
        .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY), .can_switch(can_switch),
        .master_granted(master_granted), .mstHRDATA(mstHRDATA),
        .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
        .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
        .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
        .slv_HREADY(slv_HREADY), .slv_HRDATA(slv_HRDATA),
        .slv_HREADYOUT(slv_HREADYOUT), .slv_HRESP(slv_HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        mstHSEL       = '0;
        mstHTRANS     = '0;
        mstHMASTLOCK  = '0;
        mstHWRITE     = '0;
        mstHBURST     = '0;
        mst_priority  = '0;
        can_switch    = '0;
        mstHREADY     = '1;
        slv_HREADYOUT = 1'b1;
        slv_HRDATA    = '0;
        slv_HRESP     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rot_exp[0] = 5'b00001;
        rot_exp[1] = 5'b00100;
        rot_exp[2] = 5'b10000;
        rot_exp[3] = 5'b00001;
        rot_exp[4] = 5'b00100;

        for (int m = 0; m < MASTERS; m++) begin
            mstHADDR[m]  = 64'h8000_0000 + 64'(m) * 64'h100;
            mstHWDATA[m] = 64'hDA7A_0000_0000_0000 | 64'(m);
            mstHSIZE[m]  = 3'(m);
            mstHPROT[m]  = 4'(m + 8);
        end
        idle_all();

        // Reset and idle bus
        HRESETn = 1'b0;
        tick();
        tick();
        check("rst_grant",  64'(master_granted), 64'h0);
        check("rst_hsel",   64'(slv_HSEL),       64'h0);
        check("rst_htrans", 64'(slv_HTRANS),     64'h0);
        check("rst_hready", 64'(slv_HREADY),     64'h1);
        HRESETn = 1'b1;
        tick();
        check("idle_grant", 64'(master_granted), 64'h0);
        check("idle_hsel",  64'(slv_HSEL),       64'h0);

        // Priority win, then handover once the owner allows it
        mstHSEL[1] = 1'b1; mstHTRANS[1] = HTRANS_NONSEQ; mst_priority[1] = 3'd2;
        mstHSEL[3] = 1'b1; mstHTRANS[3] = HTRANS_NONSEQ; mst_priority[3] = 3'd5;
        mstHREADY[3] = 1'b0;
        slv_HRDATA = 64'h1234_5678_9ABC_DEF0;
        slv_HRESP  = 1'b1;
        #1;
        check("pre_grant",  64'(master_granted), 64'h0);
        check("pass_rdata", mstHRDATA,           64'h1234_5678_9ABC_DEF0);
        check("pass_resp",  64'(mstHRESP),       64'h1);
        check("pass_ready", 64'(mstHREADYOUT),   64'h1);
        tick();
        check("prio_grant", 64'(master_granted), 64'h08);
        check("prio_hsel",  64'(slv_HSEL),       64'h1);
        check("prio_haddr", slv_HADDR,           64'h8000_0300);
        check("prio_hsize", 64'(slv_HSIZE),      64'h3);
        check("prio_hprot", 64'(slv_HPROT),      64'hB);
        check("prio_hrdy0", 64'(slv_HREADY),     64'h1);
        tick();
        check("hold_grant", 64'(master_granted), 64'h08);
        check("hold_wdata", slv_HWDATA,          64'hDA7A_0000_0000_0003);
        check("hold_hrdy",  64'(slv_HREADY),     64'h0);
        mstHSEL[3] = 1'b0; mstHTRANS[3] = HTRANS_IDLE; can_switch[3] = 1'b1;
        mstHREADY = '1;
        tick();
        check("hand_grant", 64'(master_granted), 64'h02);
        check("hand_haddr", slv_HADDR,           64'h8000_0100);
        idle_all();
        can_switch[1] = 1'b1;
        tick();
        check("rel_grant",  64'(master_granted), 64'h0);

        // Equal-priority round robin from a fresh reset
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        idle_all();
        for (int m = 0; m < MASTERS; m += 2) begin
            mstHSEL[m] = 1'b1; mstHTRANS[m] = HTRANS_NONSEQ; mst_priority[m] = 3'd3;
        end
        can_switch = '1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_%0d", i), 64'(master_granted), 64'(rot_exp[i]));
        end
        idle_all();
        can_switch = '1;
        tick();
        check("rr_release", 64'(master_granted), 64'h0);

        // INCR4 write with two wait states against a higher-priority requester
        idle_all();
        mstHSEL[2] = 1'b1; mstHTRANS[2] = HTRANS_NONSEQ; mstHWRITE[2] = 1'b1;
        mstHBURST[2] = HBURST_INCR4; mst_priority[2] = 3'd1;
        tick();
        check("b4_grant0",  64'(master_granted), 64'h04);
        check("b4_hwrite",  64'(slv_HWRITE),     64'h1);
        check("b4_hburst",  64'(slv_HBURST),     64'h3);
        check("b4_htrans0", 64'(slv_HTRANS),     64'h2);
        mstHTRANS[2] = HTRANS_SEQ;
        mstHSEL[4] = 1'b1; mstHTRANS[4] = HTRANS_NONSEQ; mst_priority[4] = 3'd6;
        tick();
        check("b4_grant1",  64'(master_granted), 64'h04);
        check("b4_wdata1",  slv_HWDATA,          64'hDA7A_0000_0000_0002);
        check("b4_htrans1", 64'(slv_HTRANS),     64'h3);
        slv_HREADYOUT = 1'b0;
        can_switch[2] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("b4_wait_grant%0d", i), 64'(master_granted), 64'h04);
            check($sformatf("b4_wait_wdata%0d", i), slv_HWDATA, 64'hDA7A_0000_0000_0002);
        end
        slv_HREADYOUT = 1'b1;
        can_switch[2] = 1'b0;
        tick();
        check("b4_grant2",  64'(master_granted), 64'h04);
        tick();
        check("b4_grant3",  64'(master_granted), 64'h04);
        check("b4_wdata3",  slv_HWDATA,          64'hDA7A_0000_0000_0002);
        can_switch[2] = 1'b1;
        tick();
        check("b4_handover", 64'(master_granted), 64'h10);
        check("b4_old_data", slv_HWDATA,          64'hDA7A_0000_0000_0002);
        check("b4_new_addr", slv_HADDR,           64'h8000_0400);
        idle_all();
        can_switch[4] = 1'b1;
        tick();
        check("b4_release", 64'(master_granted), 64'h0);

        // Locked sequence against a priority-7 master
        idle_all();
        mstHSEL[1] = 1'b1; mstHTRANS[1] = HTRANS_NONSEQ; mstHMASTLOCK[1] = 1'b1;
        tick();
        check("lk_grant",   64'(master_granted), 64'h02);
        check("lk_lock",    64'(slv_HMASTLOCK),  64'h1);
        mstHSEL[0] = 1'b1; mstHTRANS[0] = HTRANS_NONSEQ; mst_priority[0] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lk_hold%0d", i), 64'(master_granted), 64'h02);
        end
        can_switch[1] = 1'b1; mstHMASTLOCK[1] = 1'b0;
        tick();
        check("lk_handover", 64'(master_granted), 64'h01);
        check("lk_unlock",   64'(slv_HMASTLOCK),  64'h0);

        // Asynchronous reset in the middle of an INCR8 burst
        idle_all();
        can_switch[0] = 1'b1;
        tick();
        idle_all();
        mstHSEL[3] = 1'b1; mstHTRANS[3] = HTRANS_NONSEQ; mstHBURST[3] = HBURST_INCR8;
        mst_priority[3] = 3'd2;
        mstHREADY[3] = 1'b0;
        tick();
        check("i8_grant",   64'(master_granted), 64'h08);
        mstHTRANS[3] = HTRANS_SEQ;
        tick();
        tick();
        tick();
        check("i8_beat3",   64'(master_granted), 64'h08);
        check("i8_hready",  64'(slv_HREADY),     64'h0);
        HRESETn = 1'b0;
        #1;
        check("ar_grant",   64'(master_granted), 64'h0);
        check("ar_hsel",    64'(slv_HSEL),       64'h0);
        check("ar_htrans",  64'(slv_HTRANS),     64'h0);
        check("ar_haddr",   slv_HADDR,           64'h0);
        check("ar_hready",  64'(slv_HREADY),     64'h1);
        idle_all();
        mstHSEL[0] = 1'b1; mstHTRANS[0] = HTRANS_NONSEQ; mst_priority[0] = 3'd4;
        mstHSEL[4] = 1'b1; mstHTRANS[4] = HTRANS_NONSEQ; mst_priority[4] = 3'd4;
        #2;
        HRESETn = 1'b1;
        tick();
        check("ar_restart", 64'(master_granted), 64'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
